rtc_bcd_clock: RTL and testbench

Parametrised, fully synchronous BCD time-of-day clock for the front-panel display path. It divides the board clock to a one-second tick and keeps seconds, minutes and hours as BCD digit pairs. A field-select/load interface sets the time, with range checking. It also provides a 12/24-hour display mode and an HH:MM alarm comparator. The block drives the six 7-segment digit decoders directly and replaces the separate divider, select and cascaded-counter arrangement with a single clock domain.

---
 rtl/rtc_pkg.sv | 37 +++
 rtl/rtc_bcd_clock_bcd2_counter.sv | 54 +++++
 rtl/rtc_bcd_clock.sv | 117 +++++++++++
 tb/tb_rtc_bcd_clock.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and BCD limits for the front-panel time-of-day clock.
package rtc_pkg;

    typedef enum logic [1:0] {
        SEL_RUN  = 2'd0,
        SEL_SEC  = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_HOUR = 2'd3
    } sel_t;

    localparam logic [3:0] MAX_S1      = 4'd5;
    localparam logic [3:0] MAX_H1      = 4'd2;
    localparam logic [3:0] MAX_H0_AT_2 = 4'd3;
    localparam logic [3:0] MAX_LO      = 4'd9;

    // 24-hour BCD hour to {pm, h1, h0} in 12-hour form; midnight and noon show as 12.
    function automatic logic [8:0] to12(input logic [3:0] h1, input logic [3:0] h0);
        logic [4:0] h;
        logic [4:0] r;
        logic [8:0] res;
        h = ({1'b0, h1} * 5'd10) + {1'b0, h0};
        r = h - 5'd12;
        if (h == 5'd0) begin
            res = {1'b0, 4'd1, 4'd2};
        end else if (h < 5'd12) begin
            res = {1'b0, h1, h0};
        end else if (h == 5'd12) begin
            res = {1'b1, 4'd1, 4'd2};
        end else if (r >= 5'd10) begin
            res = {1'b1, 4'd1, 4'(r - 5'd10)};
        end else begin
            res = {1'b1, 4'd0, 4'(r)};
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_bcd_clock_bcd2_counter.sv
// Two-digit BCD counter with synchronous load, wrapping from HI_MAX:LO_MAX_AT_HI to 00.
module bcd2_counter
    import rtc_pkg::*;
#(
    parameter logic [3:0] HI_MAX       = MAX_S1,
    parameter logic [3:0] LO_MAX_AT_HI = MAX_LO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] value,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic [3:0] nxt_hi,
    output logic [3:0] nxt_lo,
    output logic       carry
);

    logic at_max;

    assign at_max = (hi == HI_MAX) && (lo == LO_MAX_AT_HI);
    assign carry  = inc && at_max;

    always_comb begin
        nxt_hi = hi;
        nxt_lo = lo;
        if (load) begin
            nxt_hi = value[7:4];
            nxt_lo = value[3:0];
        end else if (inc) begin
            if (at_max) begin
                nxt_hi = '0;
                nxt_lo = '0;
            end else if (lo == MAX_LO) begin
                nxt_hi = hi + 4'd1;
                nxt_lo = '0;
            end else begin
                nxt_lo = lo + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= nxt_hi;
            lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD time-of-day clock: one-second prescaler, field set/load, 12/24-hour display, HH:MM alarm.
module rtc_bcd_clock
    import rtc_pkg::*;
#(
    parameter int unsigned DIV      = 40_000_000,
    parameter bit          ALARM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set,
    input  logic       ld,
    input  logic [3:0] ld0,
    input  logic [3:0] ld1,
    input  logic       mode12,
    input  logic       al_en,
    input  logic [3:0] al_h1,
    input  logic [3:0] al_h0,
    input  logic [3:0] al_m1,
    input  logic [3:0] al_m0,
    output logic [3:0] S0,
    output logic [3:0] S1,
    output logic [3:0] M0,
    output logic [3:0] M1,
    output logic [3:0] H0,
    output logic [3:0] H1,
    output logic       pm,
    output logic [1:0] sel,
    output logic       tick,
    output logic       ld_err,
    output logic       alarm
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    sel_t          sel_q;
    logic          set_q;
    logic          mode_q;
    logic          fresh;
    logic          wrap;
    logic          ms_ok, h_ok;
    logic          ld_sec, ld_min, ld_hour;
    logic          s_carry, m_carry, unused_day_carry;
    logic [3:0]    s_nxt1, s_nxt0, m_nxt1, m_nxt0, h_nxt1, h_nxt0;
    logic [3:0]    h1, h0;
    logic          mode_eff;

    assign wrap = (sel_q == SEL_RUN) && (cnt == CW'(DIV - 1));

    assign ms_ok   = (ld1 <= MAX_S1) && (ld0 <= MAX_LO);
    assign h_ok    = (ld0 <= MAX_LO) &&
                     ((ld1 < MAX_H1) || ((ld1 == MAX_H1) && (ld0 <= MAX_H0_AT_2)));
    assign ld_sec  = ld && (sel_q == SEL_SEC)  && ms_ok;
    assign ld_min  = ld && (sel_q == SEL_MIN)  && ms_ok;
    assign ld_hour = ld && (sel_q == SEL_HOUR) && h_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sel_q  <= SEL_RUN;
            set_q  <= 1'b0;
            mode_q <= 1'b0;
            fresh  <= 1'b1;
            tick   <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            cnt    <= ((sel_q == SEL_RUN) && !wrap) ? cnt + CW'(1) : '0;
            set_q  <= set;
            mode_q <= mode12;
            fresh  <= 1'b0;
            tick   <= wrap;
            ld_err <= ld && !(ld_sec || ld_min || ld_hour);
            if (set && !set_q) begin
                sel_q <= sel_t'(sel_q + 2'd1);
            end
        end
    end

    bcd2_counter #(.HI_MAX(MAX_S1), .LO_MAX_AT_HI(MAX_LO)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(wrap), .load(ld_sec), .value({ld1, ld0}),
        .hi(S1), .lo(S0), .nxt_hi(s_nxt1), .nxt_lo(s_nxt0), .carry(s_carry)
    );

    bcd2_counter #(.HI_MAX(MAX_S1), .LO_MAX_AT_HI(MAX_LO)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(s_carry), .load(ld_min), .value({ld1, ld0}),
        .hi(M1), .lo(M0), .nxt_hi(m_nxt1), .nxt_lo(m_nxt0), .carry(m_carry)
    );

    bcd2_counter #(.HI_MAX(MAX_H1), .LO_MAX_AT_HI(MAX_H0_AT_2)) u_hour (
        .clk(clk), .rst_n(rst_n), .inc(m_carry), .load(ld_hour), .value({ld1, ld0}),
        .hi(h1), .lo(h0), .nxt_hi(h_nxt1), .nxt_lo(h_nxt0), .carry(unused_day_carry)
    );

    // Until the first edge after reset the live mode12 pin picks the format, so reset shows 12:00 in 12-hour mode.
    assign mode_eff = fresh ? mode12 : mode_q;
    assign {pm, H1, H0} = mode_eff ? to12(h1, h0) : {1'b0, h1, h0};
    assign sel = sel_q;

    generate
        if (ALARM_EN) begin : g_alarm
            logic alarm_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    alarm_q <= 1'b0;
                end else begin
                    alarm_q <= al_en && wrap &&
                        ({h_nxt1, h_nxt0, m_nxt1, m_nxt0, s_nxt1, s_nxt0} ==
                         {al_h1, al_h0, al_m1, al_m0, 8'h00});
                end
            end
            assign alarm = alarm_q;
        end else begin : g_no_alarm
            assign alarm = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Self-checking bench for rtc_bcd_clock: directed tables, corner sequences and a seconds-of-day reference model.
module tb_rtc_bcd_clock;

    localparam int unsigned DIV = 4;
    localparam logic [29:0] RST24 = '0;
    localparam logic [29:0] RST12 = {4'd1, 4'd2, 22'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, set, ld, mode12, al_en;
    logic [3:0] ld0, ld1, al_h1, al_h0, al_m1, al_m0;
    logic [3:0] S0, S1, M0, M1, H0, H1;
    logic       pm, tick, ld_err, alarm;
    logic [1:0] sel;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: time as seconds of day, field select as 0..3.
    int m_t, m_pc, m_sel;
    bit m_setq, m_mode, m_tick, m_err, m_alarm;

    typedef struct {
        int         field;
        logic [3:0] l1;
        logic [3:0] l0;
        logic       err;
        logic [7:0] val;
    } ld_vec_t;

    typedef struct {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [8:0] disp;
    } h12_vec_t;

    ld_vec_t  lt[12];
    h12_vec_t ht[6];

    rtc_bcd_clock #(.DIV(DIV), .ALARM_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .ld(ld), .ld0(ld0), .ld1(ld1),
        .mode12(mode12), .al_en(al_en), .al_h1(al_h1), .al_h0(al_h0),
        .al_m1(al_m1), .al_m0(al_m0), .S0(S0), .S1(S1), .M0(M0), .M1(M1),
        .H0(H0), .H1(H1), .pm(pm), .sel(sel), .tick(tick), .ld_err(ld_err),
        .alarm(alarm)
    );

    function automatic logic [29:0] dut_out();
        return {H1, H0, M1, M0, S1, S0, pm, sel, tick, ld_err, alarm};
    endfunction

    function automatic logic [23:0] time_bcd();
        return {H1, H0, M1, M0, S1, S0};
    endfunction

    function automatic void model_reset();
        m_t = 0; m_pc = 0; m_sel = 0;
        m_setq = 1'b0; m_mode = 1'b0; m_tick = 1'b0; m_err = 1'b0; m_alarm = 1'b0;
    endfunction

    function automatic void model_edge();
        int  v, hh, mm, ss, al;
        bit  wrap, ok;
        wrap    = (m_sel == 0) && (m_pc == int'(DIV) - 1);
        m_tick  = wrap;
        m_alarm = 1'b0;
        if (wrap) begin
            m_t = (m_t + 1) % 86400;
            al  = (int'(al_h1) * 10 + int'(al_h0)) * 60 + int'(al_m1) * 10 + int'(al_m0);
            m_alarm = bit'(al_en) && (m_t % 60 == 0) && (m_t / 60 == al);
        end
        m_pc = (m_sel == 0 && !wrap) ? m_pc + 1 : 0;
        hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
        v  = int'(ld1) * 10 + int'(ld0);
        ok = (ld1 <= 4'd9) && (ld0 <= 4'd9) &&
             (((m_sel == 1 || m_sel == 2) && v < 60) || (m_sel == 3 && v < 24));
        m_err = bit'(ld) && !ok;
        if (ld && ok) begin
            if (m_sel == 1) ss = v;
            if (m_sel == 2) mm = v;
            if (m_sel == 3) hh = v;
        end
        m_t = hh * 3600 + mm * 60 + ss;
        if (set && !m_setq) m_sel = (m_sel + 1) % 4;
        m_setq = bit'(set);
        m_mode = bit'(mode12);
    endfunction

    function automatic logic [29:0] model_out();
        int h, m, s, dh;
        bit p;
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        dh = h; p = 1'b0;
        if (m_mode) begin
            p  = (h >= 12);
            dh = (h % 12 == 0) ? 12 : h % 12;
        end
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                p, 2'(m_sel), m_tick, m_err, m_alarm};
    endfunction

    task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", dut_out(), model_out());
    endtask

    task automatic press_set();
        set = 1'b1; cyc();
        set = 1'b0; cyc();
    endtask

    task automatic goto_sel(input int target);
        for (int i = 0; i < 4; i++) begin
            if (m_sel != target) press_set();
        end
    endtask

    task automatic load(input logic [3:0] l1, input logic [3:0] l0);
        ld = 1'b1; ld1 = l1; ld0 = l0;
        cyc();
        ld = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        goto_sel(1); load(s[7:4], s[3:0]);
        goto_sel(2); load(m[7:4], m[3:0]);
        goto_sel(3); load(h[7:4], h[3:0]);
        goto_sel(0);
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * int'(DIV) && !seen; i++) begin
            cyc();
            seen = tick;
        end
        chk(name, 30'(seen), 30'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lt = '{
            '{1, 4'd5, 4'd9,  1'b0, 8'h59},
            '{1, 4'd6, 4'd0,  1'b1, 8'h59},
            '{1, 4'd0, 4'd10, 1'b1, 8'h59},
            '{2, 4'd3, 4'd0,  1'b0, 8'h30},
            '{2, 4'd6, 4'd0,  1'b1, 8'h30},
            '{2, 4'd5, 4'd10, 1'b1, 8'h30},
            '{3, 4'd2, 4'd4,  1'b1, 8'h00},
            '{3, 4'd2, 4'd3,  1'b0, 8'h23},
            '{3, 4'd3, 4'd0,  1'b1, 8'h23},
            '{3, 4'd1, 4'd9,  1'b0, 8'h19},
            '{3, 4'd0, 4'd12, 1'b1, 8'h19},
            '{0, 4'd1, 4'd2,  1'b1, 8'h00}
        };
        ht = '{
            '{4'd0, 4'd0, 9'h012},
            '{4'd1, 4'd2, 9'h112},
            '{4'd1, 4'd3, 9'h101},
            '{4'd0, 4'd1, 9'h001},
            '{4'd1, 4'd1, 9'h011},
            '{4'd2, 4'd3, 9'h111}
        };

        rst_n = 1'b0; set = 1'b0; ld = 1'b0; ld0 = '0; ld1 = '0;
        mode12 = 1'b0; al_en = 1'b0;
        al_h1 = '0; al_h0 = '0; al_m1 = '0; al_m0 = '0;
        model_reset();

        // Reset state in both display modes.
        #22;
        chk("reset_24h", dut_out(), RST24);
        mode12 = 1'b1; #1;
        chk("reset_12h", dut_out(), RST12);
        mode12 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 60 ticks: tick every DIV cycles, first at DIV, seconds roll into minutes.
        for (int k = 1; k <= 60 * int'(DIV); k++) begin
            cyc();
            chk("tick_period", 30'(tick), 30'(k % int'(DIV) == 0));
        end
        chk("after_60_ticks", 30'({M1, M0, S1, S0}), 30'(16'h0100));

        // 23:59:59 rolls to 00:00:00 in one edge.
        set_time(8'h23, 8'h59, 8'h59);
        chk("pre_midnight", 30'(time_bcd()), 30'(24'h235959));
        wait_tick("midnight_tick");
        chk("midnight", 30'(time_bcd()), 30'(24'h000000));

        // Load validation table.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] fv;
            goto_sel(lt[i].field);
            load(lt[i].l1, lt[i].l0);
            chk("ld_err", 30'(ld_err), 30'(lt[i].err));
            fv = (lt[i].field == 1) ? {S1, S0} : (lt[i].field == 2) ? {M1, M0} : {H1, H0};
            if (lt[i].field != 0) chk("ld_field", 30'(fv), 30'(lt[i].val));
        end

        // 12-hour display table.
        for (int i = 0; i < 6; i++) begin
            goto_sel(3);
            load(ht[i].h1, ht[i].h0);
            mode12 = 1'b1; cyc();
            chk("disp12", 30'({pm, H1, H0}), 30'(ht[i].disp));
            mode12 = 1'b0; cyc();
        end

        // Alarm: fires on the tick to 07:30:00, not when disabled, not on a load.
        al_h1 = 4'd0; al_h0 = 4'd7; al_m1 = 4'd3; al_m0 = 4'd0;
        al_en = 1'b1;
        set_time(8'h07, 8'h29, 8'h59);
        chk("pre_alarm", 30'(time_bcd()), 30'(24'h072959));
        wait_tick("alarm_tick");
        chk("alarm_fire", 30'(alarm), 30'(1));
        chk("alarm_time", 30'(time_bcd()), 30'(24'h073000));
        cyc();
        chk("alarm_one_cycle", 30'(alarm), 30'(0));
        al_en = 1'b0;
        set_time(8'h07, 8'h29, 8'h59);
        wait_tick("noalarm_tick");
        chk("alarm_disabled", 30'(alarm), 30'(0));
        al_en = 1'b1;
        set_time(8'h07, 8'h30, 8'h00);
        chk("alarm_on_load", 30'(alarm), 30'(0));
        wait_tick("post_load_tick");
        chk("alarm_after_load", 30'(alarm), 30'(0));
        chk("post_load_time", 30'(time_bcd()), 30'(24'h073001));
        al_en = 1'b0;

        // Reset mid-count in RUN.
        goto_sel(0);
        for (int i = 0; i < 6; i++) cyc();
        #2 rst_n = 1'b0; #1;
        chk("rst_mid_run", dut_out(), RST24);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset with sel=HOUR in 12-hour mode; values hold until the first edge after release.
        goto_sel(3);
        load(4'd1, 4'd5);
        mode12 = 1'b1; cyc();
        #2 rst_n = 1'b0; #1;
        chk("rst_hour_12h", dut_out(), RST12);
        chk("rst_sel", 30'(sel), 30'(0));
        mode12 = 1'b0; #1;
        chk("rst_hour_24h", dut_out(), RST24);
        mode12 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        chk("rst_hold", dut_out(), RST12);
        model_reset();
        cyc();
        mode12 = 1'b0; cyc();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int nm;
            if ($urandom_range(0, 9) == 0) set = ~set;
            ld  = ($urandom_range(0, 5) == 0);
            ld1 = 4'($urandom_range(0, 7));
            ld0 = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 49) == 0) mode12 = ~mode12;
            if ($urandom_range(0, 99) == 0) al_en = ~al_en;
            if ($urandom_range(0, 29) == 0) begin
                nm = (m_t / 60 + 1) % 1440;
                al_h1 = 4'((nm / 60) / 10); al_h0 = 4'((nm / 60) % 10);
                al_m1 = 4'((nm % 60) / 10); al_m0 = 4'((nm % 60) % 10);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
